// File: rtl/alu181_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu181_pkg
// Brief    : Shared types and constants for the serial 74181-style ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu181_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Common function selects; the mode bit that goes with each is noted.
    localparam logic [3:0] S_ADD = 4'b1001;  // m = 0
    localparam logic [3:0] S_SUB = 4'b0110;  // m = 0
    localparam logic [3:0] S_XOR = 4'b0110;  // m = 1

endpackage
`default_nettype wire

// File: rtl/alu181_slice.sv
`default_nettype none
// ============================================================================
// Module   : alu181_slice
// Brief    : Combinational 4-bit 74181-style slice, active-low carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
module alu181_slice
    import alu181_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic [3:0]         s,
    input  logic               m,
    input  logic               cn_b,
    output logic [SLICE_W-1:0] f,
    output logic               cn4_b
);

    logic [SLICE_W-1:0] w_e;
    logic [SLICE_W-1:0] w_d;
    logic [SLICE_W-1:0] w_c_b;
    logic               w_y;

    assign w_e = ~((a & b & {SLICE_W{s[3]}}) | (a & ~b & {SLICE_W{s[2]}}));
    assign w_d = ~((~b & {SLICE_W{s[1]}}) | (b & {SLICE_W{s[0]}}) | a);

    // In the active-low carry domain a bit propagates "no carry" when e=1
    // and forces "no carry" when e&d=1.
    assign w_c_b[0] = cn_b;
    assign w_c_b[1] = (w_e[0] & w_d[0]) | (w_e[0] & cn_b);
    assign w_c_b[2] = (w_e[1] & w_d[1]) | (w_e[1] & w_e[0] & w_d[0])
                    | (w_e[1] & w_e[0] & cn_b);
    assign w_c_b[3] = (w_e[2] & w_d[2]) | (w_e[2] & w_e[1] & w_d[1])
                    | (w_e[2] & w_e[1] & w_e[0] & w_d[0])
                    | (w_e[2] & w_e[1] & w_e[0] & cn_b);

    assign w_y = ~((w_e[3] & w_d[3]) | (w_e[3] & w_e[2] & w_d[2])
                 | (w_e[3] & w_e[2] & w_e[1] & w_d[1])
                 | (w_e[3] & w_e[2] & w_e[1] & w_e[0] & w_d[0]));

    assign cn4_b = ~(w_y & ~(&w_e & cn_b));
    assign f     = w_e ^ w_d ^ (~w_c_b | {SLICE_W{m}});

endmodule
`default_nettype wire

// File: rtl/alu181_serial.sv
`default_nettype none
// ============================================================================
// Module   : alu181_serial
// Brief    : WIDTH-bit 74181-style ALU evaluated one slice per clock, LS first.
// Revision : 1.0 - initial release
// ============================================================================
module alu181_serial
    import alu181_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout_b,
    output logic             aeb
);

    localparam int              NSLICE     = WIDTH / SLICE_W;
    localparam int              IDX_W      = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_f;
    logic [3:0]         r_s;
    logic               r_m;
    logic               r_carry_b;
    logic               r_aeb;
    logic [IDX_W-1:0]   r_idx;
    logic               w_accept;
    logic               w_last;
    logic [SLICE_W-1:0] w_a_sl [NSLICE];
    logic [SLICE_W-1:0] w_b_sl [NSLICE];
    logic [SLICE_W-1:0] w_slice_f;
    logic               w_slice_cn4_b;

    generate
        for (genvar k = 0; k < NSLICE; k++) begin : g_split
            assign w_a_sl[k] = r_a[k*SLICE_W +: SLICE_W];
            assign w_b_sl[k] = r_b[k*SLICE_W +: SLICE_W];
        end
    endgenerate

    alu181_slice u_slice (
        .a     (w_a_sl[r_idx]),
        .b     (w_b_sl[r_idx]),
        .s     (r_s),
        .m     (r_m),
        .cn_b  (r_carry_b),
        .f     (w_slice_f),
        .cn4_b (w_slice_cn4_b)
    );

    assign w_last = (r_idx == C_LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_s       <= '0;
            r_m       <= 1'b0;
            r_carry_b <= 1'b1;
            r_idx     <= '0;
            r_f       <= '0;
            r_aeb     <= 1'b0;
        end else if (w_accept) begin
            r_a       <= a;
            r_b       <= b;
            r_s       <= s;
            r_m       <= m;
            r_carry_b <= cn_b;
            r_idx     <= '0;
            r_aeb     <= 1'b1;
        end else if (r_state == RUN) begin
            for (int k = 0; k < NSLICE; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_f[k*SLICE_W +: SLICE_W] <= w_slice_f;
                end
            end
            r_carry_b <= w_slice_cn4_b;
            r_aeb     <= r_aeb & (&w_slice_f);
            r_idx     <= r_idx + IDX_W'(1);
        end
    end

    assign f      = r_f;
    assign cout_b = r_carry_b;
    assign aeb    = r_aeb;

endmodule
`default_nettype wire

// File: tb/tb_alu181_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu181_serial
// Brief    : Self-checking bench for alu181_serial against a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu181_serial;
    import alu181_pkg::*;

    localparam int W  = 16;
    localparam int NS = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   s;
    logic         m;
    logic         cn_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] f;
    logic         cout_b;
    logic         aeb;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   s;
        logic         m;
        logic         cn;
        logic [W-1:0] f;
        logic         co;
        logic         aeb;
    } vec_t;

    alu181_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .cn_b      (cn_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .cout_b    (cout_b),
        .aeb       (aeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level 74181 function table: every arithmetic function is X + Y + carry,
    // e.g. X = A|B, Y = A&B gives A plus B; logic mode returns ~(X ^ Y).
    // Result packing: {cout_b, aeb, f}.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [3:0] ms, input logic mm,
                                           input logic mcn);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] fv;
        logic [W:0]   sum;
        x   = (~mb & {W{ms[1]}}) | (mb & {W{ms[0]}}) | ma;
        y   = (ma & mb & {W{ms[3]}}) | (ma & ~mb & {W{ms[2]}});
        sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~mcn};
        fv  = mm ? ~(x ^ y) : sum[W-1:0];
        return {~sum[W], &fv, fv};
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic [3:0] ts, input logic tm, input logic tcn,
                          output logic [W-1:0] rf, output logic rco, output logic raeb,
                          output int lat);
        @(negedge clk);
        a = ta; b = tbv; s = ts; m = tm; cn_b = tcn; in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        // Scramble inputs after acceptance; the result must not depend on them.
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = ~tm; cn_b = ~tcn;
        while (lat < 40) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        rf = f; rco = cout_b; raeb = aeb;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (f !== '0) begin
            failures++; $display("FAIL reset_f: got %h want 0000", f);
        end
        checks++;
        if (cout_b !== 1'b1) begin
            failures++; $display("FAIL reset_cout_b: got %b want 1", cout_b);
        end
        checks++;
        if (aeb !== 1'b0) begin
            failures++; $display("FAIL reset_aeb: got %b want 0", aeb);
        end
    endtask

    task automatic test_directed();
        vec_t         v [7];
        logic [W-1:0] rf;
        logic         rco;
        logic         raeb;
        int           lat;
        v[0] = '{16'h00FF, 16'h0001, S_ADD, 1'b0, 1'b1, 16'h0100, 1'b1, 1'b0};
        v[1] = '{16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        v[2] = '{16'h1234, 16'h1234, S_SUB, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        v[3] = '{16'h1234, 16'h1235, S_SUB, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0};
        v[4] = '{16'h0005, 16'h0003, S_SUB, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        v[5] = '{16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b1, 16'h0FF0, 1'b1, 1'b0};
        v[6] = '{16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b0, 16'h0FF0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            run_op(v[i].a, v[i].b, v[i].s, v[i].m, v[i].cn, rf, rco, raeb, lat);
            checks++;
            if (lat != NS + 1) begin
                failures++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NS + 1);
            end
            checks++;
            if (rf !== v[i].f) begin
                failures++; $display("FAIL dir%0d_f: got %h want %h", i, rf, v[i].f);
            end
            checks++;
            if (rco !== v[i].co) begin
                failures++; $display("FAIL dir%0d_cout_b: got %b want %b", i, rco, v[i].co);
            end
            checks++;
            if (raeb !== v[i].aeb) begin
                failures++; $display("FAIL dir%0d_aeb: got %b want %b", i, raeb, v[i].aeb);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ta, tbv, rf;
        logic [3:0]   ts;
        logic         tm, tcn, rco, raeb;
        logic [W+1:0] exp;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            ta  = W'($urandom);
            tbv = W'($urandom);
            if (i % 8 == 0) ta = '1;
            if (i % 8 == 1) tbv = ta;
            ts  = 4'($urandom);
            tm  = 1'($urandom);
            tcn = 1'($urandom);
            exp = model(ta, tbv, ts, tm, tcn);
            run_op(ta, tbv, ts, tm, tcn, rf, rco, raeb, lat);
            checks++;
            if ({rco, raeb, rf} !== exp || lat != NS + 1) begin
                failures++;
                $display("FAIL rand%0d a=%h b=%h s=%b m=%b cn_b=%b: got f=%h cout_b=%b aeb=%b lat=%0d want f=%h cout_b=%b aeb=%b lat=%0d",
                         i, ta, tbv, ts, tm, tcn, rf, rco, raeb, lat,
                         exp[W-1:0], exp[W+1], exp[W], NS + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ta, tbv;
        logic [3:0]   ts;
        logic         tm, tcn;
        logic [W+1:0] exp;
        int           n;
        ta = W'($urandom); tbv = W'($urandom); ts = 4'($urandom);
        tm = 1'($urandom); tcn = 1'($urandom);
        exp = model(ta, tbv, ts, tm, tcn);
        @(negedge clk);
        out_ready = 1'b0;
        a = ta; b = tbv; s = ts; m = tm; cn_b = tcn; in_valid = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid === 1'b1) break;
            checks++;
            if (in_ready !== 1'b0) begin
                failures++; $display("FAIL bp_run_in_ready: got %b want 0", in_ready);
            end
            a = W'($urandom); b = W'($urandom); s = 4'($urandom);
            in_valid = n[0];
            n++;
        end
        checks++;
        if (n != NS) begin
            failures++; $display("FAIL bp_run_cycles: got %0d want %0d", n, NS);
        end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || f !== exp[W-1:0] ||
                cout_b !== exp[W+1] || aeb !== exp[W]) begin
                failures++;
                $display("FAIL bp_hold%0d: got out_valid=%b in_ready=%b f=%h cout_b=%b aeb=%b want 1 0 f=%h cout_b=%b aeb=%b",
                         k, out_valid, in_ready, f, cout_b, aeb, exp[W-1:0], exp[W+1], exp[W]);
            end
            in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] ta, tbv, rf;
        logic [3:0]   ts;
        logic         tm, tcn, rco, raeb;
        logic [W+1:0] exp;
        int           lat;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001; s = S_ADD; m = 1'b0; cn_b = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || f !== '0 || cout_b !== 1'b1 || aeb !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_run: got in_ready=%b out_valid=%b f=%h cout_b=%b aeb=%b want 1 0 0000 1 0",
                     in_ready, out_valid, f, cout_b, aeb);
        end
        rst_n = 1'b1;
        ta = W'($urandom); tbv = W'($urandom); ts = 4'($urandom);
        tm = 1'($urandom); tcn = 1'($urandom);
        exp = model(ta, tbv, ts, tm, tcn);
        run_op(ta, tbv, ts, tm, tcn, rf, rco, raeb, lat);
        checks++;
        if ({rco, raeb, rf} !== exp || lat != NS + 1) begin
            failures++;
            $display("FAIL rst_fresh_op: got f=%h cout_b=%b aeb=%b lat=%0d want f=%h cout_b=%b aeb=%b lat=%0d",
                     rf, rco, raeb, lat, exp[W-1:0], exp[W+1], exp[W], NS + 1);
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] expq [$];
        logic [W+1:0] e;
        int           last_acc, accepts, cyc;
        last_acc = -1; accepts = 0; cyc = 0;
        a = W'($urandom); b = W'($urandom); s = 4'($urandom);
        m = 1'($urandom); cn_b = 1'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        while (cyc < 60 && (accepts < 3 || expq.size() > 0)) begin
            @(negedge clk);
            cyc++;
            if (out_valid === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected: got out_valid=1 want 0");
                end else begin
                    e = expq.pop_front();
                    if ({cout_b, aeb, f} !== e) begin
                        failures++;
                        $display("FAIL b2b_result: got f=%h cout_b=%b aeb=%b want f=%h cout_b=%b aeb=%b",
                                 f, cout_b, aeb, e[W-1:0], e[W+1], e[W]);
                    end
                end
            end
            if (in_ready === 1'b1 && in_valid) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != NS + 2) begin
                        failures++;
                        $display("FAIL b2b_gap: got %0d want %0d", cyc - last_acc, NS + 2);
                    end
                end
                last_acc = cyc;
                accepts++;
                expq.push_back(model(a, b, s, m, cn_b));
            end else begin
                in_valid = (accepts < 3);
                a = W'($urandom); b = W'($urandom); s = 4'($urandom);
                m = 1'($urandom); cn_b = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (accepts != 3 || expq.size() != 0) begin
            failures++;
            $display("FAIL b2b_incomplete: got accepts=%0d pending=%0d want 3 0", accepts, expq.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; s = '0; m = 1'b0; cn_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
